gate_rr_arbiter: RTL and testbench

Round-robin arbiter and response sequencer that shares one N-input selectable gate evaluator among M requesters. Each requester submits an N-bit operand vector plus a 2-bit gate select over a valid/ready handshake. The winner's request is evaluated through an `N_Any_Gate` instance: 00 AND, 01 XOR, 10 XNOR, 11 OR. The result is returned through a single registered response channel tagged with the requester ID. The block sits between the requesting control units and the shared gate datapath.

---
 rtl/gate_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_gate_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_rr_arbiter.sv
// Round-robin arbiter that shares one selectable N-input gate among M requesters
// and returns each result through a single registered, ID-tagged response slot.
module gate_rr_arbiter #(
  parameter int unsigned N = 2,
  parameter int unsigned M = 4,
  localparam int unsigned IDW = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [M-1:0]     req_valid,
  input  logic [M*N-1:0]   req_data,
  input  logic [2*M-1:0]   req_select,
  output logic [M-1:0]     req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_out,
  output logic [IDW-1:0]   rsp_id,
  output logic [15:0]      grant_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_out_q, rsp_out_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  logic             accept_c;
  logic             grant_any_c;
  logic [IDW-1:0]   grant_idx_c;
  logic [M-1:0]     grant_c;
  logic             transfer_c;
  logic [N-1:0]     gate_data_c;
  logic [1:0]       gate_sel_c;
  logic             gate_y_c;

  // Rotating priority scan: first valid requester starting at ptr, wrapping.
  always_comb begin
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    grant_c     = '0;
    for (int unsigned k = 0; k < M; k++) begin
      logic [IDW-1:0] idx;
      idx = IDW'((32'(ptr_q) + k) % M);
      if (!grant_any_c && req_valid[idx]) begin
        grant_any_c = 1'b1;
        grant_idx_c = idx;
      end
    end
    if (grant_any_c) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

  // Handshake: slot free or draining this cycle lets the winner through.
  always_comb begin
    accept_c    = !rsp_valid_q || rsp_ready;
    req_ready   = accept_c ? grant_c : '0;
    transfer_c  = accept_c && grant_any_c;
    gate_data_c = req_data[32'(grant_idx_c)*N +: N];
    gate_sel_c  = req_select[32'(grant_idx_c)*2 +: 2];
  end

  N_Any_Gate #(.N(N)) u_gate (
    .a   (gate_data_c),
    .sel (gate_sel_c),
    .y   (gate_y_c)
  );

  // Next-state: load on transfer, drop valid on a pure drain, otherwise hold.
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_id_d    = rsp_id_q;
    grant_cnt_d = grant_cnt_q;
    if (transfer_c) begin
      rsp_valid_d = 1'b1;
      rsp_out_d   = gate_y_c;
      rsp_id_d    = grant_idx_c;
      ptr_d       = IDW'((32'(grant_idx_c) + 32'd1) % M);
      if (grant_cnt_q != {CNT_W{1'b1}}) begin
        grant_cnt_d = grant_cnt_q + CNT_W'(1);
      end
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 1'b0;
      rsp_id_q    <= '0;
      grant_cnt_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_id_q    <= rsp_id_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_id    = rsp_id_q;
  assign grant_cnt = grant_cnt_q;

endmodule

// Selectable N-input reduction gate: 00 AND, 01 XOR, 10 XNOR, 11 OR.
module N_Any_Gate #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] a,
  input  logic [1:0]   sel,
  output logic         y
);

  // Reduction chosen by sel.
  always_comb begin
    y = 1'b0;
    case (sel)
      2'b00:   y = &a;
      2'b01:   y = ^a;
      2'b10:   y = ~^a;
      default: y = |a;
    endcase
  end

endmodule

// File: tb/tb_gate_rr_arbiter.sv
// Directed testbench for gate_rr_arbiter (N=4, M=4).
module tb_gate_rr_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned M = 4;

  logic          clk;
  logic          rst;
  logic [M-1:0]  req_valid;
  logic [M*N-1:0] req_data;
  logic [2*M-1:0] req_select;
  logic [M-1:0]  req_ready;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_out;
  logic [1:0]    rsp_id;
  logic [15:0]   grant_cnt;

  int checks;
  int failures;
  logic [15:0] exp_cnt;

  gate_rr_arbiter #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_select (req_select),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_out    (rsp_out),
    .rsp_id     (rsp_id),
    .grant_cnt  (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_select = '0;
    rsp_ready = 1'b1;
    step();
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid: got %0h expected 0", rsp_valid); end
    checks++; if (rsp_out !== 1'b0) begin failures++; $display("FAIL reset_rsp_out: got %0h expected 0", rsp_out); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id: got %0h expected 0", rsp_id); end
    checks++; if (grant_cnt !== 16'h0) begin failures++; $display("FAIL reset_grant_cnt: got %0h expected 0", grant_cnt); end
    checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL reset_ptr: got %0h expected 0", dut.ptr_q); end
    rst = 1'b0;
    exp_cnt = 16'h0;
  endtask

  task automatic test_modes();
    logic [3:0] md [4];
    logic [1:0] ms [4];
    logic       mexp [4];
    md = '{4'hF, 4'h7, 4'h7, 4'h0};
    ms = '{2'b00, 2'b01, 2'b10, 2'b11};
    mexp = '{1'b1, 1'b1, 1'b0, 1'b0};
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      req_data = {12'h000, md[k]};
      req_select = {6'b000000, ms[k]};
      #1;
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL modes_ready[%0d]: got %b expected 0001", k, req_ready); end
      step();
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL modes_valid[%0d]: got %0h expected 1", k, rsp_valid); end
      checks++; if (rsp_out !== mexp[k]) begin failures++; $display("FAIL modes_out[%0d]: got %0h expected %0h", k, rsp_out, mexp[k]); end
      checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL modes_id[%0d]: got %0h expected 0", k, rsp_id); end
    end
    checks++; if (grant_cnt !== 16'd4) begin failures++; $display("FAIL modes_cnt: got %0h expected 4", grant_cnt); end
    req_valid = '0;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL modes_drain_valid: got %0h expected 0", rsp_valid); end
    checks++; if (rsp_out !== 1'b0) begin failures++; $display("FAIL modes_drain_out_hold: got %0h expected 0", rsp_out); end
  endtask

  task automatic test_round_robin();
    logic rexp [4];
    rexp = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 16'h0;
    // r0: 0001 XOR=1, r1: 0011 AND=0, r2: 1111 XNOR=1, r3: 0000 OR=0
    req_data = {4'h0, 4'hF, 4'h3, 4'h1};
    req_select = {2'b11, 2'b10, 2'b00, 2'b01};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, 4'(1 << (k % 4))); end
      step();
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (rsp_id !== 2'(k % 4)) begin failures++; $display("FAIL rr_id[%0d]: got %0h expected %0h", k, rsp_id, k % 4); end
      checks++; if (rsp_out !== rexp[k % 4]) begin failures++; $display("FAIL rr_out[%0d]: got %0h expected %0h", k, rsp_out, rexp[k % 4]); end
    end
    checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL rr_ptr_wrap: got %0h expected 0", dut.ptr_q); end
    checks++; if (grant_cnt !== exp_cnt) begin failures++; $display("FAIL rr_cnt: got %0h expected %0h", grant_cnt, exp_cnt); end
    req_valid = '0;
    step();
  endtask

  task automatic test_skip_wrap();
    req_valid = 4'b0010;
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (rsp_id !== 2'd1) begin failures++; $display("FAIL skip_first_id: got %0h expected 1", rsp_id); end
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL skip_ready3: got %b expected 1000", req_ready); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (rsp_id !== 2'd3) begin failures++; $display("FAIL skip_id3: got %0h expected 3", rsp_id); end
    checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL skip_ptr_after3: got %0h expected 0", dut.ptr_q); end
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL skip_ready0: got %b expected 0001", req_ready); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL skip_id0: got %0h expected 0", rsp_id); end
    checks++; if (dut.ptr_q !== 2'd1) begin failures++; $display("FAIL skip_ptr_after0: got %0h expected 1", dut.ptr_q); end
    req_valid = '0;
    step();
  endtask

  task automatic test_backpressure();
    // ptr=1, requesters 0 and 2 valid: 2 wins first
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL bp_first_id: got %0h expected 2", rsp_id); end
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %0h expected 1", k, rsp_valid); end
      checks++; if (rsp_id !== 2'd2) begin failures++; $display("FAIL bp_id[%0d]: got %0h expected 2", k, rsp_id); end
      checks++; if (rsp_out !== 1'b1) begin failures++; $display("FAIL bp_out[%0d]: got %0h expected 1", k, rsp_out); end
      checks++; if (dut.ptr_q !== 2'd3) begin failures++; $display("FAIL bp_ptr[%0d]: got %0h expected 3", k, dut.ptr_q); end
      checks++; if (grant_cnt !== exp_cnt) begin failures++; $display("FAIL bp_cnt[%0d]: got %0h expected %0h", k, grant_cnt, exp_cnt); end
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready: got %b expected 0001", req_ready); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid: got %0h expected 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL bp_release_id: got %0h expected 0", rsp_id); end
    checks++; if (grant_cnt !== exp_cnt) begin failures++; $display("FAIL bp_release_cnt: got %0h expected %0h", grant_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %0h expected 0", rsp_valid); end
    checks++; if (rsp_out !== 1'b0) begin failures++; $display("FAIL rstmid_out: got %0h expected 0", rsp_out); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL rstmid_id: got %0h expected 0", rsp_id); end
    checks++; if (grant_cnt !== 16'h0) begin failures++; $display("FAIL rstmid_cnt: got %0h expected 0", grant_cnt); end
    checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL rstmid_ptr: got %0h expected 0", dut.ptr_q); end
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL rstmid_first_ready: got %b expected 0001", req_ready); end
    step();
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL rstmid_first_id: got %0h expected 0", rsp_id); end
    req_valid = '0;
    step();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    checks++; if (grant_cnt !== 16'hFFFE) begin failures++; $display("FAIL sat_pre: got %0h expected fffe", grant_cnt); end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (grant_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold[%0d]: got %0h expected ffff", k, grant_cnt); end
    end
    req_valid = '0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_cnt = 16'h0;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_select = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_modes();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
